// File: rtl/tcp_pkg.sv
// Shared TCP receive-path types: payload buffer descriptors and the verdict
// record carried through the RX payload dispatch queue.
package tcp_pkg;

    localparam int FLOWID_W       = 8;
    localparam int PAYLOAD_ADDR_W = 16;
    localparam int PAYLOAD_LEN_W  = 16;

    typedef struct packed {
        logic [PAYLOAD_ADDR_W-1:0] payload_addr;
        logic [PAYLOAD_LEN_W-1:0]  payload_len;
    } payload_buf_struct;

    localparam int PAYLOAD_BUF_STRUCT_W = $bits(payload_buf_struct);

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        logic                accept;
        payload_buf_struct   payload_entry;
    } rx_dispatch_entry_struct;

    localparam int RX_DISPATCH_ENTRY_W = $bits(rx_dispatch_entry_struct);

    // Only accepted packets that actually carry bytes go to the commit engine.
    function automatic logic entry_is_commit(input rx_dispatch_entry_struct e);
        return e.accept && (e.payload_entry.payload_len != {PAYLOAD_LEN_W{1'b0}});
    endfunction

endpackage

// File: rtl/tcp_rx_dispatch_fifo.sv
// In-order queue with extended pointers; ready and empty are registered so
// neither depends combinationally on the pop request.
module tcp_rx_dispatch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_val,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_rdy,
    output logic                     rd_val,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     rd_pop,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             empty_r;
    logic             wr_rdy_r;

    logic             push_s;
    logic             pop_s;
    logic [AW:0]      wr_ptr_nxt_s;
    logic [AW:0]      rd_ptr_nxt_s;
    logic             full_nxt_s;
    logic             empty_nxt_s;

    // Next pointer values and the full/empty flags they imply.
    always_comb begin
        push_s = wr_val && wr_rdy_r;
        pop_s  = rd_pop && !empty_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s  = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                      (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
    end

    // Pointer and flag state; ready stays low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            empty_r  <= 1'b1;
            wr_rdy_r <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            empty_r  <= empty_nxt_s;
            wr_rdy_r <= !full_nxt_s;
        end
    end

    // Entry storage; contents are meaningless while the slot is not live.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    assign wr_rdy    = wr_rdy_r;
    assign rd_val    = !empty_r;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];
    assign occupancy = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/tcp_rx_payload_dispatch.sv
// Steers queued RX verdicts in strict order to either the payload commit
// engine or the payload buffer allocator, with saturating statistics.
module tcp_rx_payload_dispatch
    import tcp_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_W       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tcp_rx_dst_hdr_val,
    input  logic [FLOWID_W-1:0]           tcp_rx_dst_flowid,
    input  logic                          tcp_rx_dst_pkt_accept,
    input  payload_buf_struct             tcp_rx_dst_payload_entry,
    output logic                          dst_tcp_rx_hdr_rdy,
    output logic                          commit_req_val,
    output logic [FLOWID_W-1:0]           commit_req_flowid,
    output payload_buf_struct             commit_req_entry,
    input  logic                          commit_req_rdy,
    output logic                          free_req_val,
    output payload_buf_struct             free_req_entry,
    input  logic                          free_req_rdy,
    output logic [CNT_W-1:0]              stat_commit_cnt,
    output logic [CNT_W-1:0]              stat_free_cnt,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_occupancy
);

    localparam int QW = RX_DISPATCH_ENTRY_W + 1;

    rx_dispatch_entry_struct wr_entry_s;
    rx_dispatch_entry_struct head_entry_s;
    logic [QW-1:0]           wr_word_s;
    logic [QW-1:0]           head_word_s;
    logic                    head_val_s;
    logic                    head_is_commit_s;
    logic                    commit_hs_s;
    logic                    free_hs_s;
    logic                    pop_s;
    logic [CNT_W-1:0]        stat_commit_cnt_r;
    logic [CNT_W-1:0]        stat_free_cnt_r;

    // The class bit is computed once at push and stored with the entry.
    always_comb begin
        wr_entry_s.flowid        = tcp_rx_dst_flowid;
        wr_entry_s.accept        = tcp_rx_dst_pkt_accept;
        wr_entry_s.payload_entry = tcp_rx_dst_payload_entry;
        wr_word_s                = {entry_is_commit(wr_entry_s), wr_entry_s};
    end

    tcp_rx_dispatch_fifo #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .wr_val    (tcp_rx_dst_hdr_val),
        .wr_data   (wr_word_s),
        .wr_rdy    (dst_tcp_rx_hdr_rdy),
        .rd_val    (head_val_s),
        .rd_data   (head_word_s),
        .rd_pop    (pop_s),
        .occupancy (queue_occupancy)
    );

    assign head_is_commit_s = head_word_s[QW-1];
    assign head_entry_s     = head_word_s[QW-2:0];

    assign commit_req_val    = head_val_s && head_is_commit_s;
    assign free_req_val      = head_val_s && !head_is_commit_s;
    assign commit_req_flowid = head_entry_s.flowid;
    assign commit_req_entry  = head_entry_s.payload_entry;
    assign free_req_entry    = head_entry_s.payload_entry;

    assign commit_hs_s = commit_req_val && commit_req_rdy;
    assign free_hs_s   = free_req_val && free_req_rdy;
    assign pop_s       = commit_hs_s || free_hs_s;

    // Saturating handshake counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_commit_cnt_r <= {CNT_W{1'b0}};
            stat_free_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (commit_hs_s && (stat_commit_cnt_r != {CNT_W{1'b1}})) begin
                stat_commit_cnt_r <= stat_commit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (free_hs_s && (stat_free_cnt_r != {CNT_W{1'b1}})) begin
                stat_free_cnt_r <= stat_free_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stat_commit_cnt = stat_commit_cnt_r;
    assign stat_free_cnt   = stat_free_cnt_r;

endmodule

// File: tb/tb_tcp_rx_payload_dispatch.sv
// Directed bench for tcp_rx_payload_dispatch with a scoreboard queue of
// expected outputs; built with a 4-bit counter width to reach saturation.
module tb_tcp_rx_payload_dispatch;
    import tcp_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  tcp_rx_dst_hdr_val = 1'b0;
    logic [FLOWID_W-1:0]   tcp_rx_dst_flowid = 8'd0;
    logic                  tcp_rx_dst_pkt_accept = 1'b0;
    payload_buf_struct     tcp_rx_dst_payload_entry = '0;
    logic                  dst_tcp_rx_hdr_rdy;
    logic                  commit_req_val;
    logic [FLOWID_W-1:0]   commit_req_flowid;
    payload_buf_struct     commit_req_entry;
    logic                  commit_req_rdy = 1'b0;
    logic                  free_req_val;
    payload_buf_struct     free_req_entry;
    logic                  free_req_rdy = 1'b0;
    logic [CW-1:0]         stat_commit_cnt;
    logic [CW-1:0]         stat_free_cnt;
    logic [2:0]            queue_occupancy;

    tcp_rx_payload_dispatch #(.QUEUE_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .tcp_rx_dst_hdr_val       (tcp_rx_dst_hdr_val),
        .tcp_rx_dst_flowid        (tcp_rx_dst_flowid),
        .tcp_rx_dst_pkt_accept    (tcp_rx_dst_pkt_accept),
        .tcp_rx_dst_payload_entry (tcp_rx_dst_payload_entry),
        .dst_tcp_rx_hdr_rdy       (dst_tcp_rx_hdr_rdy),
        .commit_req_val           (commit_req_val),
        .commit_req_flowid        (commit_req_flowid),
        .commit_req_entry         (commit_req_entry),
        .commit_req_rdy           (commit_req_rdy),
        .free_req_val             (free_req_val),
        .free_req_entry           (free_req_entry),
        .free_req_rdy             (free_req_rdy),
        .stat_commit_cnt          (stat_commit_cnt),
        .stat_free_cnt            (stat_free_cnt),
        .queue_occupancy          (queue_occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_commit;
        logic [7:0]  flowid;
        logic [15:0] addr;
        logic [15:0] len;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   exp_commit_cnt = 0;
    int   exp_free_cnt = 0;
    logic push_seen = 1'b0;
    logic mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: compare outputs against the model, then advance it.
    always @(negedge clk) begin
        exp_t f;
        exp_t n;
        logic exp_rdy, exp_cv, exp_fv;
        push_seen = 1'b0;
        if (mon_en) begin
            exp_rdy = (sb.size() < DEPTH);
            exp_cv  = (sb.size() > 0) && sb[0].is_commit;
            exp_fv  = (sb.size() > 0) && !sb[0].is_commit;
            check("hdr_rdy", 64'(dst_tcp_rx_hdr_rdy), 64'(exp_rdy));
            check("commit_val", 64'(commit_req_val), 64'(exp_cv));
            check("free_val", 64'(free_req_val), 64'(exp_fv));
            check("occupancy", 64'(queue_occupancy), 64'(sb.size()));
            check("commit_cnt", 64'(stat_commit_cnt), 64'(exp_commit_cnt));
            check("free_cnt", 64'(stat_free_cnt), 64'(exp_free_cnt));
            if (sb.size() > 0) begin
                f = sb[0];
                if (f.is_commit) begin
                    check("commit_flowid", 64'(commit_req_flowid), 64'(f.flowid));
                    check("commit_addr", 64'(commit_req_entry.payload_addr), 64'(f.addr));
                    check("commit_len", 64'(commit_req_entry.payload_len), 64'(f.len));
                end else begin
                    check("free_addr", 64'(free_req_entry.payload_addr), 64'(f.addr));
                    check("free_len", 64'(free_req_entry.payload_len), 64'(f.len));
                end
            end
            if (exp_cv && commit_req_rdy) begin
                void'(sb.pop_front());
                if (exp_commit_cnt < CMAX) exp_commit_cnt++;
            end else if (exp_fv && free_req_rdy) begin
                void'(sb.pop_front());
                if (exp_free_cnt < CMAX) exp_free_cnt++;
            end
            if (tcp_rx_dst_hdr_val && exp_rdy) begin
                n.is_commit = tcp_rx_dst_pkt_accept && (tcp_rx_dst_payload_entry.payload_len != 16'd0);
                n.flowid    = tcp_rx_dst_flowid;
                n.addr      = tcp_rx_dst_payload_entry.payload_addr;
                n.len       = tcp_rx_dst_payload_entry.payload_len;
                sb.push_back(n);
                push_seen = 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the push edge.
    task automatic push(input logic [7:0] fl, input logic acc, input logic [15:0] addr, input logic [15:0] len);
        int n;
        tcp_rx_dst_hdr_val = 1'b1;
        tcp_rx_dst_flowid = fl;
        tcp_rx_dst_pkt_accept = acc;
        tcp_rx_dst_payload_entry.payload_addr = addr;
        tcp_rx_dst_payload_entry.payload_len = len;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!push_seen && n < 200);
        #1;
        tcp_rx_dst_hdr_val = 1'b0;
        check("push_timeout", 64'(n < 200), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_timeout", 64'(n < 200), 64'd1);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 64'(dst_tcp_rx_hdr_rdy), 64'd0);
        check("rst_commit_val", 64'(commit_req_val), 64'd0);
        check("rst_free_val", 64'(free_req_val), 64'd0);
        check("rst_occ", 64'(queue_occupancy), 64'd0);
        check("rst_cnt", 64'({stat_commit_cnt, stat_free_cnt}), 64'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_rst", 64'(dst_tcp_rx_hdr_rdy), 64'd1);
        mon_en = 1'b1;

        // Single commit
        commit_req_rdy = 1'b1;
        free_req_rdy = 1'b1;
        push(8'd3, 1'b1, 16'h0100, 16'd64);
        drain();
        check("single_commit_cnt", 64'(stat_commit_cnt), 64'd1);

        // Reject and zero-length
        push(8'd5, 1'b0, 16'h0200, 16'd100);
        push(8'd6, 1'b1, 16'h0300, 16'd0);
        drain();
        check("reject_free_cnt", 64'(stat_free_cnt), 64'd2);
        check("reject_commit_cnt", 64'(stat_commit_cnt), 64'd1);

        // Full queue with a held fifth push
        commit_req_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(10 + i), 1'b1, 16'(16'h1000 + i), 16'(8 + i));
        check("full_occ", 64'(queue_occupancy), 64'd4);
        check("full_rdy", 64'(dst_tcp_rx_hdr_rdy), 64'd0);
        tcp_rx_dst_hdr_val = 1'b1;
        tcp_rx_dst_flowid = 8'd14;
        tcp_rx_dst_pkt_accept = 1'b1;
        tcp_rx_dst_payload_entry.payload_addr = 16'h1004;
        tcp_rx_dst_payload_entry.payload_len = 16'd12;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            check("fifth_held", 64'(push_seen), 64'd0);
        end
        #1 commit_req_rdy = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!push_seen && n < 200);
        #1 tcp_rx_dst_hdr_val = 1'b0;
        check("fifth_timeout", 64'(n < 200), 64'd1);
        drain();
        check("full_drained_occ", 64'(queue_occupancy), 64'd0);

        // Head-of-line ordering
        commit_req_rdy = 1'b0;
        push(8'd1, 1'b1, 16'h2000, 16'd20);
        push(8'd9, 1'b0, 16'h2100, 16'd8);
        push(8'd2, 1'b1, 16'h2200, 16'd30);
        repeat (4) @(posedge clk);
        #1;
        check("hol_free_blocked", 64'(free_req_val), 64'd0);
        check("hol_occ", 64'(queue_occupancy), 64'd3);
        commit_req_rdy = 1'b1;
        drain();
        check("hol_free_cnt", 64'(stat_free_cnt), 64'd3);

        // Streaming with pointer wrap and counter saturation
        for (int i = 0; i < 20; i++) begin
            push(8'(32 + i), 1'b1, 16'(16'h3000 + i), 16'(i + 1));
            check("stream_occ", 64'(queue_occupancy <= 3'd1), 64'd1);
        end
        drain();
        check("commit_saturated", 64'(stat_commit_cnt), 64'd15);

        // Reset mid-operation
        commit_req_rdy = 1'b0;
        free_req_rdy = 1'b0;
        push(8'd40, 1'b1, 16'h4000, 16'd4);
        push(8'd41, 1'b0, 16'h4100, 16'd4);
        push(8'd42, 1'b1, 16'h4200, 16'd4);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_commit_val", 64'(commit_req_val), 64'd0);
        check("mid_rst_free_val", 64'(free_req_val), 64'd0);
        check("mid_rst_occ", 64'(queue_occupancy), 64'd0);
        check("mid_rst_rdy", 64'(dst_tcp_rx_hdr_rdy), 64'd0);
        check("mid_rst_cnt", 64'({stat_commit_cnt, stat_free_cnt}), 64'd0);
        sb.delete();
        exp_commit_cnt = 0;
        exp_free_cnt = 0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        commit_req_rdy = 1'b1;
        free_req_rdy = 1'b1;
        push(8'd7, 1'b1, 16'h0700, 16'd32);
        drain();
        check("post_rst_commit_cnt", 64'(stat_commit_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
